sevenseg_scan: RTL and testbench

Parametrised N-digit multiplexed seven-segment display driver for Tiny Tapeout designs. It replaces the fixed two-digit, decimal-only tens/ones mux with a configurable digit count and refresh divider. It adds hex/decimal glyph modes, per-digit decimal points, leading-zero suppression and blanking. Value updates are double-buffered, so a new number only takes effect at a frame boundary and never tears across digits. It sits between the game logic (which supplies a packed BCD/hex value) and the `uo_out` pins.

---
 rtl/sevenseg_scan_if.sv | 29 ++
 rtl/sevenseg_scan.sv | 135 +++++++++++++
 tb/tb_sevenseg_scan.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/sevenseg_scan_if.sv
// Bundle between game logic and the multiplexed seven-segment scanner.
// master = value/mode producer, slave = scanner driving the display pins.
interface sevenseg_scan_if #(
  parameter int unsigned DIGITS = 2
);
  localparam int unsigned IW = $clog2(DIGITS);

  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp_in;
  logic                load;
  logic                hex_mode;
  logic                lzs;
  logic                blank;
  logic [6:0]          seg;
  logic                dp;
  logic [DIGITS-1:0]   dig_sel;
  logic [IW-1:0]       dig_idx;
  logic                frame_done;

  modport master (
    output value, dp_in, load, hex_mode, lzs, blank,
    input  seg, dp, dig_sel, dig_idx, frame_done
  );

  modport slave (
    input  value, dp_in, load, hex_mode, lzs, blank,
    output seg, dp, dig_sel, dig_idx, frame_done
  );
endinterface

// File: rtl/sevenseg_scan.sv
// N-digit multiplexed seven-segment driver with double-buffered value updates,
// hex/decimal glyphs, per-digit decimal points, leading-zero suppression and blanking.
module sevenseg_scan #(
  parameter int unsigned DIGITS      = 2,
  parameter int unsigned REFRESH_DIV = 4
) (
  input logic           clk,
  input logic           reset,
  sevenseg_scan_if.slave bus
);
  localparam int unsigned IW = $clog2(DIGITS);
  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CntLast = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IdxLast = IW'(DIGITS - 1);

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] disp_val_q, disp_val_d, pend_val_q, pend_val_d;
  logic [DIGITS-1:0]   disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
  logic                pend_v_q, pend_v_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   dig_sel_q, dig_sel_d;
  logic                frame_done_q, frame_done_d;

  logic                digit_end, wrap, all_zero;
  logic [3:0]          nib;
  logic [DIGITS-1:0]   zero_from;

  function automatic logic [6:0] glyph(input logic [3:0] n, input logic hex);
    logic [6:0] g;
    g = '0;
    case (n)
      4'h0: g = 7'b0111111;
      4'h1: g = 7'b0000110;
      4'h2: g = 7'b1011011;
      4'h3: g = 7'b1001111;
      4'h4: g = 7'b1100110;
      4'h5: g = 7'b1101101;
      4'h6: g = 7'b1111101;
      4'h7: g = 7'b0000111;
      4'h8: g = 7'b1111111;
      4'h9: g = 7'b1101111;
      4'hA: g = hex ? 7'b1110111 : 7'b0000000;
      4'hB: g = hex ? 7'b1111100 : 7'b0000000;
      4'hC: g = hex ? 7'b0111001 : 7'b0000000;
      4'hD: g = hex ? 7'b1011110 : 7'b0000000;
      4'hE: g = hex ? 7'b1111001 : 7'b0000000;
      4'hF: g = hex ? 7'b1110001 : 7'b0000000;
    endcase
    return g;
  endfunction

  always_comb begin
    digit_end = (cnt_q == CntLast);
    wrap      = digit_end && (idx_q == IdxLast);
    cnt_d     = digit_end ? '0 : cnt_q + CW'(1);
    idx_d     = idx_q;
    if (digit_end) idx_d = wrap ? '0 : idx_q + IW'(1);

    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    pend_v_d   = pend_v_q;
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    if (bus.load) begin
      pend_val_d = bus.value;
      pend_dp_d  = bus.dp_in;
      pend_v_d   = 1'b1;
    end
    // A load landing on the boundary edge bypasses the pending buffer.
    if (wrap) begin
      pend_v_d = 1'b0;
      if (bus.load) begin
        disp_val_d = bus.value;
        disp_dp_d  = bus.dp_in;
      end else if (pend_v_q) begin
        disp_val_d = pend_val_q;
        disp_dp_d  = pend_dp_q;
      end
    end
    frame_done_d = wrap;

    all_zero = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      all_zero     = all_zero && (disp_val_q[4*i +: 4] == 4'h0);
      zero_from[i] = all_zero;
    end

    nib       = disp_val_q[{idx_q, 2'b00} +: 4];
    seg_d     = glyph(nib, bus.hex_mode);
    if (bus.lzs && (idx_q != '0) && zero_from[idx_q]) seg_d = '0;
    dp_d      = disp_dp_q[idx_q];
    dig_sel_d = DIGITS'(1) << idx_q;
    if (bus.blank) begin
      seg_d     = '0;
      dp_d      = 1'b0;
      dig_sel_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_v_q     <= 1'b0;
      seg_q        <= '0;
      dp_q         <= 1'b0;
      dig_sel_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_v_q     <= pend_v_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      dig_sel_q    <= dig_sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.dig_sel    = dig_sel_q;
  assign bus.dig_idx    = idx_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed bench: 2-digit/div-4 instance for scan, buffering, hex and reset;
// 4-digit/div-1 instance for leading-zero suppression and blanking.
module tb_sevenseg_scan;
  localparam logic [6:0] G0 = 7'b0111111, G1 = 7'b0000110, G2 = 7'b1011011;
  localparam logic [6:0] G3 = 7'b1001111, G5 = 7'b1101101, G6 = 7'b1111101;
  localparam logic [6:0] G7 = 7'b0000111, G9 = 7'b1101111, GA = 7'b1110111;
  localparam logic [6:0] GF = 7'b1110001;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  sevenseg_scan_if #(.DIGITS(2)) bus_a ();
  sevenseg_scan_if #(.DIGITS(4)) bus_b ();

  sevenseg_scan #(.DIGITS(2), .REFRESH_DIV(4)) dut_a (.clk(clk), .reset(rst_a), .bus(bus_a));
  sevenseg_scan #(.DIGITS(4), .REFRESH_DIV(1)) dut_b (.clk(clk), .reset(rst_b), .bus(bus_b));

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset;
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.value = '0; bus_a.dp_in = '0; bus_a.load = 0;
    bus_a.hex_mode = 0; bus_a.lzs = 0; bus_a.blank = 0;
    bus_b.value = 16'h0050; bus_b.dp_in = 4'b0100; bus_b.load = 0;
    bus_b.hex_mode = 0; bus_b.lzs = 1; bus_b.blank = 0;
    #12;
    tests++;
    if ({bus_a.seg, bus_a.dp, bus_a.dig_sel, bus_a.frame_done, bus_a.dig_idx} !== 12'd0) begin
      fails++;
      $display("FAIL reset_outputs got seg=%b dp=%b sel=%b fd=%b idx=%b want all 0",
               bus_a.seg, bus_a.dp, bus_a.dig_sel, bus_a.frame_done, bus_a.dig_idx);
    end
    @(posedge clk); #1;
    rst_a = 1'b0; cyc = 0;
    tick;
    tests++;
    if (bus_a.seg !== G0 || bus_a.dig_sel !== 2'b01 || bus_a.dig_idx !== 1'b0) begin
      fails++;
      $display("FAIL first_edge got seg=%b sel=%b idx=%b want seg=%b sel=01 idx=0",
               bus_a.seg, bus_a.dig_sel, bus_a.dig_idx, G0);
    end
  endtask

  task automatic test_scan;
    logic [6:0] es;
    logic [1:0] el;
    while (cyc < 5) tick;
    bus_a.value = 8'h23; bus_a.load = 1;
    tick;
    bus_a.load = 0;
    for (int k = 6; k <= 8; k++) begin
      if (k > 6) tick;
      tests++;
      if (bus_a.seg !== G0) begin
        fails++;
        $display("FAIL scan_pre_boundary k=%0d got %b want %b", cyc, bus_a.seg, G0);
      end
    end
    for (int k = 9; k <= 24; k++) begin
      tick;
      es = (((cyc - 1) / 4) % 2 == 0) ? G3 : G2;
      el = (((cyc - 1) / 4) % 2 == 0) ? 2'b01 : 2'b10;
      tests++;
      if (bus_a.seg !== es || bus_a.dig_sel !== el || bus_a.frame_done !== (cyc % 8 == 0)) begin
        fails++;
        $display("FAIL scan k=%0d got seg=%b sel=%b fd=%b want seg=%b sel=%b fd=%b", cyc,
                 bus_a.seg, bus_a.dig_sel, bus_a.frame_done, es, el, (cyc % 8 == 0));
      end
    end
  endtask

  task automatic test_mid_frame_load;
    logic [6:0] es;
    while (cyc < 25) tick;
    bus_a.value = 8'h45; bus_a.load = 1;
    tick;
    bus_a.value = 8'h67;
    tick;
    bus_a.load = 0;
    for (int k = 27; k <= 40; k++) begin
      if (k > 27) tick;
      if (cyc <= 32) es = (((cyc - 1) / 4) % 2 == 0) ? G3 : G2;
      else           es = (((cyc - 1) / 4) % 2 == 0) ? G7 : G6;
      tests++;
      if (bus_a.seg !== es) begin
        fails++;
        $display("FAIL mid_frame_load k=%0d got %b want %b", cyc, bus_a.seg, es);
      end
    end
  endtask

  task automatic test_back_to_back;
    while (cyc < 47) tick;
    bus_a.value = 8'h91; bus_a.load = 1;
    tick;
    bus_a.load = 0;
    tests++;
    if (bus_a.frame_done !== 1'b1 || dut_a.pend_v_q !== 1'b0) begin
      fails++;
      $display("FAIL load_at_boundary got fd=%b pend_v=%b want fd=1 pend_v=0",
               bus_a.frame_done, dut_a.pend_v_q);
    end
    tick;
    tests++;
    if (bus_a.seg !== G1 || bus_a.dig_sel !== 2'b01) begin
      fails++;
      $display("FAIL load_at_boundary_d0 got seg=%b sel=%b want %b sel=01",
               bus_a.seg, bus_a.dig_sel, G1);
    end
    while (cyc < 53) tick;
    tests++;
    if (bus_a.seg !== G9 || bus_a.dig_sel !== 2'b10) begin
      fails++;
      $display("FAIL load_at_boundary_d1 got seg=%b sel=%b want %b sel=10",
               bus_a.seg, bus_a.dig_sel, G9);
    end
  endtask

  task automatic test_hex;
    logic [6:0] es;
    logic [1:0] el;
    bus_a.hex_mode = 1; bus_a.value = 8'hAF; bus_a.load = 1;
    tick;
    bus_a.load = 0;
    while (cyc < 56) tick;
    for (int k = 57; k <= 72; k++) begin
      if (k == 65) bus_a.hex_mode = 0;
      tick;
      el = (((cyc - 1) / 4) % 2 == 0) ? 2'b01 : 2'b10;
      if (cyc > 64) es = 7'b0000000;
      else          es = (el == 2'b01) ? GF : GA;
      tests++;
      if (bus_a.seg !== es || bus_a.dig_sel !== el) begin
        fails++;
        $display("FAIL hex k=%0d got seg=%b sel=%b want seg=%b sel=%b", cyc,
                 bus_a.seg, bus_a.dig_sel, es, el);
      end
    end
    bus_a.hex_mode = 1;
  endtask

  task automatic test_reset_mid;
    logic [1:0] el;
    while (cyc < 73) tick;
    bus_a.value = 8'h88; bus_a.load = 1;
    tick;
    bus_a.load = 0;
    while (cyc < 78) tick;
    tests++;
    if (bus_a.seg !== GA || bus_a.dig_sel !== 2'b10 || bus_a.dig_idx !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset got seg=%b sel=%b idx=%b want %b sel=10 idx=1",
               bus_a.seg, bus_a.dig_sel, bus_a.dig_idx, GA);
    end
    #1 rst_a = 1'b1;
    #1;
    tests++;
    if ({bus_a.seg, bus_a.dp, bus_a.dig_sel, bus_a.frame_done, bus_a.dig_idx} !== 12'd0) begin
      fails++;
      $display("FAIL async_reset got seg=%b dp=%b sel=%b fd=%b idx=%b want all 0",
               bus_a.seg, bus_a.dp, bus_a.dig_sel, bus_a.frame_done, bus_a.dig_idx);
    end
    #1 rst_a = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 16; k++) begin
      tick;
      el = (((cyc - 1) / 4) % 2 == 0) ? 2'b01 : 2'b10;
      tests++;
      if (bus_a.seg !== G0 || bus_a.dig_sel !== el || bus_a.frame_done !== (cyc % 8 == 0)) begin
        fails++;
        $display("FAIL after_reset k=%0d got seg=%b sel=%b fd=%b want seg=%b sel=%b fd=%b",
                 cyc, bus_a.seg, bus_a.dig_sel, bus_a.frame_done, G0, el, (cyc % 8 == 0));
      end
    end
  endtask

  task automatic test_lzs_blank;
    logic [6:0] es;
    logic       ed;
    logic [3:0] el;
    @(posedge clk); #1;
    rst_b = 1'b0; cyc = 0;
    bus_b.load = 1;
    tick;
    bus_b.load = 0;
    while (cyc < 4) tick;
    tests++;
    if (bus_b.frame_done !== 1'b1) begin
      fails++;
      $display("FAIL lzs_frame k=%0d got fd=%b want 1", cyc, bus_b.frame_done);
    end
    for (int k = 5; k <= 16; k++) begin
      if (k == 9) bus_b.blank = 1;
      tick;
      case ((cyc - 1) % 4)
        0:       begin es = G0;   ed = 0; el = 4'b0001; end
        1:       begin es = G5;   ed = 0; el = 4'b0010; end
        2:       begin es = '0;   ed = 1; el = 4'b0100; end
        default: begin es = '0;   ed = 0; el = 4'b1000; end
      endcase
      if (cyc > 8) begin es = '0; ed = 0; el = '0; end
      tests++;
      if (bus_b.seg !== es || bus_b.dp !== ed || bus_b.dig_sel !== el ||
          bus_b.frame_done !== (cyc % 4 == 0)) begin
        fails++;
        $display("FAIL lzs_blank k=%0d got seg=%b dp=%b sel=%b fd=%b want seg=%b dp=%b sel=%b fd=%b",
                 cyc, bus_b.seg, bus_b.dp, bus_b.dig_sel, bus_b.frame_done, es, ed, el,
                 (cyc % 4 == 0));
      end
    end
    bus_b.blank = 0;
  endtask

  initial begin
    test_reset;
    test_scan;
    test_mid_frame_load;
    test_back_to_back;
    test_hex;
    test_reset_mid;
    test_lzs_blank;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
